p2s_scheduler: RTL

P2S_SCHEDULER -- requirements
Module: p2s_scheduler

---
 rtl/p2s_pkg.sv | 13 +
 rtl/p2s_shift_core.sv | 40 ++++
 rtl/p2s_scheduler.sv | 122 ++++++++++++
 3 files changed

// File: rtl/p2s_pkg.sv
// Shared definitions for the parallel-to-serial scheduler: FSM encoding and
// default word width / requester count.
package p2s_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREQ  = 4;

endpackage

// File: rtl/p2s_shift_core.sv
// LSB-first shift register with a wrapping bit counter; last flags bit WIDTH-1.
module p2s_shift_core
    import p2s_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             bit_out,
    output logic             last
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] sreg_r;
    logic [CW-1:0]    cnt_r;

    assign last    = (cnt_r == CW'(WIDTH - 1));
    assign bit_out = sreg_r[0];

    // Load restarts the frame at bit 0; otherwise shift right and wrap the count at WIDTH-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_r <= '0;
            cnt_r  <= '0;
        end else if (load) begin
            sreg_r <= din;
            cnt_r  <= '0;
        end else begin
            sreg_r <= sreg_r >> 1;
            if (last) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

endmodule

// File: rtl/p2s_scheduler.sv
// Round-robin scheduler that grants one requester at a time and streams its
// word LSB-first on sout, chaining frames back-to-back when requests are pending.
module p2s_scheduler
    import p2s_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   data,
    output logic [NREQ-1:0]         gnt,
    output logic                    sout,
    output logic                    sout_valid,
    output logic                    sout_first,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy
);
    localparam int IW = $clog2(NREQ);

    state_t           state_r;
    state_t           state_next_s;
    logic [IW-1:0]    last_grant_r;
    logic [IW-1:0]    owner_r;
    logic [IW-1:0]    win_s;
    logic             win_found_s;
    logic             load_s;
    logic             first_r;
    logic             bit_s;
    logic             last_s;
    logic [WIDTH-1:0] din_s;
    logic [NREQ-1:0]  gnt_s;

    // Round-robin pick: scan downwards so the nearest requester after last_grant wins
    always_comb begin
        win_s       = '0;
        win_found_s = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(last_grant_r) + k) % NREQ]) begin
                win_s       = IW'((int'(last_grant_r) + k) % NREQ);
                win_found_s = 1'b1;
            end
        end
    end

    assign din_s = data[int'(win_s)*WIDTH +: WIDTH];

    // Next state and grant; grants only from IDLE or on the last bit of a frame
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    load_s       = 1'b1;
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_s && win_found_s) begin
                    load_s       = 1'b1;
                    state_next_s = ST_SHIFT;
                end else if (last_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        // gnt is combinational, so reset must mask it without waiting for an edge
        if (load_s && !rst) begin
            gnt_s = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
        end else begin
            gnt_s = '0;
        end
    end

    // State, arbitration pointer, frame owner and first-bit flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            last_grant_r <= IW'(NREQ - 1);
            owner_r      <= '0;
            first_r      <= 1'b0;
        end else begin
            state_r <= state_next_s;
            first_r <= load_s;
            if (load_s) begin
                last_grant_r <= win_s;
                owner_r      <= win_s;
            end else begin
                last_grant_r <= last_grant_r;
                owner_r      <= owner_r;
            end
        end
    end

    p2s_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (load_s),
        .din     (din_s),
        .bit_out (bit_s),
        .last    (last_s)
    );

    assign gnt        = gnt_s;
    assign busy       = (state_r == ST_SHIFT);
    assign sout_valid = busy;
    assign sout_first = first_r;
    assign sout       = busy & bit_s;
    assign owner      = owner_r;

endmodule
